ex_mem_stage: RTL and testbench

Pipeline stage directly downstream of the MIPS ALU. It registers the ALU `result`/`zero` outputs together with the instruction's memory and writeback controls, then presents them to the data-memory stage over a valid/ready handshake. A 2-entry skid buffer absorbs memory-stage back-pressure without losing or reordering instructions. Optionally, it resolves BEQ branches from the ALU `zero` flag.

---
 rtl/ex_mem_stage.sv | 147 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer on a valid/ready output.
// Optional BEQ resolution from the ALU zero flag when EX_MEM_BRANCH_RESOLVE_EN is defined.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              is_branch,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_pc
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd_addr;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } entry_t;

    logic   out_vld_q, out_vld_d;
    logic   skid_vld_q, skid_vld_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   xfer;
    logic   out_free;

    assign accept   = in_valid & ~skid_vld_q & ~flush;
    assign xfer     = out_vld_q & out_ready;
    assign out_free = ~out_vld_q | xfer;

    // Branch entries travel as bubbles: no register, load or store side effects.
    always_comb begin
        in_entry            = '0;
        in_entry.result     = alu_result;
        in_entry.store_data = store_data;
        in_entry.rd_addr    = rd_addr;
        in_entry.mem_read   = mem_read & ~is_branch;
        in_entry.mem_write  = mem_write & ~is_branch;
        in_entry.reg_write  = reg_write & ~is_branch;
    end

    // Entry movement; SKID always drains into OUT before new input can enter OUT.
    always_comb begin
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        out_d      = out_q;
        skid_d     = skid_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_d = in_entry;
                end
            end
        end else if (accept) begin
            skid_d     = in_entry;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
    logic              br_taken_q, br_taken_d;
    logic [DATA_W-1:0] br_pc_q, br_pc_d;

    // Taken BEQ pulses for one cycle after its accept edge.
    always_comb begin
        br_taken_d = accept & is_branch & alu_zero;
        br_pc_d    = br_pc_q;
        if (br_taken_d) begin
            br_pc_d = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_q <= 1'b0;
            br_pc_q    <= '0;
        end else begin
            br_taken_q <= br_taken_d;
            br_pc_q    <= br_pc_d;
        end
    end

    assign branch_taken = br_taken_q;
    assign branch_pc    = br_pc_q;
`else
    logic unused_branch;
    assign unused_branch = ^{branch_target, alu_zero};
    assign branch_taken  = 1'b0;
    assign branch_pc     = '0;
`endif

    assign in_ready       = ~skid_vld_q;
    assign out_valid      = out_vld_q;
    assign out_result     = out_q.result;
    assign out_store_data = out_q.store_data;
    assign out_rd_addr    = out_q.rd_addr;
    assign out_mem_read   = out_q.mem_read;
    assign out_mem_write  = out_q.mem_write;
    assign out_reg_write  = out_q.reg_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage: queue models stage contents and order.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        mem_read, mem_write, reg_write;
    logic        is_branch;
    logic [31:0] branch_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd_addr;
    logic        out_mem_read, out_mem_write, out_reg_write;
    logic        branch_taken;
    logic [31:0] branch_pc;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .store_data(store_data), .rd_addr(rd_addr),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .is_branch(is_branch), .branch_target(branch_target),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_rd_addr(out_rd_addr),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write),
        .branch_taken(branch_taken), .branch_pc(branch_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        exp_bt = 1'b0;
    logic [31:0] exp_bpc = 32'h0;
    logic        last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        if (sb.size() > 0) begin
            chk("out_result", out_result, sb[0].res);
            chk("out_store_data", out_store_data, sb[0].sd);
            chk("out_rd_addr", 32'(out_rd_addr), 32'(sb[0].rd));
            chk("out_ctrl", 32'({out_mem_read, out_mem_write, out_reg_write}),
                32'({sb[0].mr, sb[0].mw, sb[0].rw}));
        end
        chk("branch_taken", 32'(branch_taken), 32'(exp_bt));
        if (exp_bt) chk("branch_pc", branch_pc, exp_bpc);
`ifndef EX_MEM_BRANCH_RESOLVE_EN
        chk("branch_pc_zero", branch_pc, 32'h0);
`endif
    endtask

    // Advance one clock with the currently driven inputs, updating the model.
    task automatic step();
        logic acc, xf, bt;
        exp_t e;
        acc = in_valid && (sb.size() < 2) && !flush;
        xf  = (sb.size() > 0) && out_ready;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        bt  = acc && is_branch && alu_zero;
`else
        bt  = 1'b0;
`endif
        e.res = alu_result;
        e.sd  = store_data;
        e.rd  = rd_addr;
        e.mr  = mem_read && !is_branch;
        e.mw  = mem_write && !is_branch;
        e.rw  = reg_write && !is_branch;
        @(posedge clk);
        if (flush) sb.delete();
        else begin
            if (xf) void'(sb.pop_front());
            if (acc) sb.push_back(e);
        end
        exp_bt = bt;
        if (bt) exp_bpc = branch_target;
        last_acc = acc;
        @(negedge clk);
        check_all();
    endtask

    task automatic offer(input logic [31:0] res, input logic [4:0] rd);
        in_valid   = 1'b1;
        alu_result = res;
        store_data = ~res;
        rd_addr    = rd;
        mem_read   = res[0];
        mem_write  = res[1];
        reg_write  = 1'b1;
        is_branch  = 1'b0;
        alu_zero   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; alu_zero = 1'b0;
        store_data = '0; rd_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; is_branch = 1'b0; branch_target = '0; flush = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_ctrl", 32'({out_mem_read, out_mem_write, out_reg_write}), 32'h0);
        chk("rst_branch", 32'(branch_taken), 32'h0);
        chk("rst_branch_pc", branch_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            offer(32'(i), 5'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Back-pressure: A in OUT, B in SKID, C refused until room opens
        out_ready = 1'b0;
        offer(32'hA, 5'd10); step();
        offer(32'hB, 5'd11); step();
        offer(32'hC, 5'd12); step();
        chk("c_not_taken_stalled", 32'(last_acc), 32'h0);
        step();
        out_ready = 1'b1;
        begin
            logic got_c = 1'b0;
            for (int n = 0; n < 5 && !got_c; n++) begin
                step();
                got_c = last_acc;
            end
            chk("c_accepted", 32'(got_c), 32'h1);
        end
        in_valid = 1'b0;
        step(); step(); step();

        // Flush with both entries full and a concurrent input
        out_ready = 1'b0;
        offer(32'hD, 5'd13); step();
        offer(32'hE, 5'd14); step();
        offer(32'hF, 5'd15); flush = 1'b1; out_ready = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        step(); step();

        // Branch, taken then not taken
        offer(32'h0, 5'd3);
        mem_write = 1'b1; mem_read = 1'b1;
        is_branch = 1'b1; alu_zero = 1'b1; branch_target = 32'h0040_0020;
        step();
        in_valid = 1'b0; is_branch = 1'b0; alu_zero = 1'b0;
        step(); step();
        offer(32'h5, 5'd4);
        is_branch = 1'b1; alu_zero = 1'b0; branch_target = 32'h0040_0040;
        step();
        in_valid = 1'b0; is_branch = 1'b0;
        step();

        // Flushed branch must not pulse
        offer(32'h0, 5'd5);
        is_branch = 1'b1; alu_zero = 1'b1; branch_target = 32'h0040_0080;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; is_branch = 1'b0; alu_zero = 1'b0;
        step();

        // Asynchronous reset in the middle of a full stall
        out_ready = 1'b0;
        offer(32'h11, 5'd6); step();
        offer(32'h22, 5'd7); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        exp_bt = 1'b0;
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_in_ready", 32'(in_ready), 32'h1);
        chk("async_rst_out_result", out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        offer(32'h33, 5'd8); step();
        in_valid = 1'b0; step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
